// File: rtl/tb_sched_pkg.sv
// Shared types for the traceback job scheduler: FSM states, the latched job record
// and the field widths used by the scheduler and its arbiter.
package tb_sched_pkg;

  localparam int W_LEN   = 5;
  localparam int W_ID    = 2;
  localparam int W_STATE = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENG_RST = 2'd1,
    RUN     = 2'd2,
    RESP    = 2'd3
  } state_t;

  typedef struct packed {
    logic [W_LEN-1:0]   diag;
    logic [W_LEN-1:0]   score;
    logic [W_STATE-1:0] tb_state;
    logic [W_ID-1:0]    id;
  } job_t;

  // Next round-robin start position after lane v was served, wrapping at n.
  function automatic logic [W_ID-1:0] wrap_inc(input logic [W_ID-1:0] v, input int n);
    if (int'(v) + 1 >= n) return '0;
    return v + 1'b1;
  endfunction

endpackage

// File: rtl/tb_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first valid lane at or above ptr_i,
// wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int LOG_NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]     valid_i,
  input  logic [LOG_NUM_REQ-1:0] ptr_i,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic [LOG_NUM_REQ-1:0] id_o,
  output logic                   any_o
);

  always_comb begin
    int idx;
    grant_o = '0;
    id_o    = '0;
    any_o   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_i) + k) % NUM_REQ;
      if (!any_o && valid_i[idx]) begin
        any_o        = 1'b1;
        grant_o[idx] = 1'b1;
        id_o         = LOG_NUM_REQ'(idx);
      end
    end
  end

endmodule

// File: rtl/tb_job_scheduler.sv
// Serialises traceback jobs from NUM_REQ lanes onto one engine, owning the engine reset.
// Optional watchdog on RUN is enabled with the TB_JOB_TIMEOUT_EN macro.
module tb_job_scheduler
  import tb_sched_pkg::*;
#(
  parameter int NUM_REQ               = 4,
  parameter int LOG_NUM_REQ           = W_ID,
  parameter int LOG_MAX_WAVEFRONT_LEN = W_LEN,
  parameter int ENGINE_RST_CYCLES     = 2
`ifdef TB_JOB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES        = 1024
`endif
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ*LOG_MAX_WAVEFRONT_LEN-1:0] req_start_diag,
  input  logic [NUM_REQ*LOG_MAX_WAVEFRONT_LEN-1:0] req_start_score,
  input  logic [NUM_REQ*2-1:0]                   req_tb_state,
  output logic                                   tb_rst,
  output logic                                   tb_start_traceback,
  output logic [LOG_MAX_WAVEFRONT_LEN-1:0]       tb_start_diag,
  output logic [LOG_MAX_WAVEFRONT_LEN-1:0]       tb_start_score,
  output logic [1:0]                             tb_state_out,
  input  logic                                   tb_stop_traceback,
  input  logic [LOG_MAX_WAVEFRONT_LEN-1:0]       tb_num_compact,
  output logic                                   resp_valid,
  input  logic                                   resp_ready,
  output logic [LOG_NUM_REQ-1:0]                 resp_id,
  output logic [LOG_MAX_WAVEFRONT_LEN-1:0]       resp_num_compact,
  output logic                                   busy,
`ifdef TB_JOB_TIMEOUT_EN
  output logic                                   resp_timeout,
`endif
  output state_t                                 dbg_state
);

  // Response channel: a result transfers on a cycle where resp_valid & resp_ready are
  // both high; once raised, resp_valid and all resp_* fields hold until that transfer.

  localparam int RCW = $clog2(ENGINE_RST_CYCLES + 1);

  state_t                           state_q;
  job_t                             job_q, job_d;
  logic [LOG_NUM_REQ-1:0]           rr_ptr_q, rr_ptr_d;
  logic [RCW-1:0]                   rst_cnt_q;
  logic                             start_q;
  logic                             resp_valid_q;
  logic [LOG_NUM_REQ-1:0]           resp_id_q;
  logic [LOG_MAX_WAVEFRONT_LEN-1:0] resp_num_q;

  logic [NUM_REQ-1:0]               grant;
  logic [LOG_NUM_REQ-1:0]           grant_id;
  logic                             grant_any;

`ifdef TB_JOB_TIMEOUT_EN
  localparam int TMW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMW-1:0] tmo_cnt_q;
  logic           resp_timeout_q;
`endif

  rr_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .LOG_NUM_REQ (LOG_NUM_REQ)
  ) u_arb (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .id_o    (grant_id),
    .any_o   (grant_any)
  );

  always_comb begin
    job_d          = '0;
    job_d.diag     = req_start_diag[grant_id*LOG_MAX_WAVEFRONT_LEN +: LOG_MAX_WAVEFRONT_LEN];
    job_d.score    = req_start_score[grant_id*LOG_MAX_WAVEFRONT_LEN +: LOG_MAX_WAVEFRONT_LEN];
    job_d.tb_state = req_tb_state[grant_id*2 +: 2];
    job_d.id       = grant_id;
    rr_ptr_d       = wrap_inc(grant_id, NUM_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      job_q        <= '0;
      rr_ptr_q     <= '0;
      rst_cnt_q    <= '0;
      start_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_num_q   <= '0;
`ifdef TB_JOB_TIMEOUT_EN
      tmo_cnt_q      <= '0;
      resp_timeout_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            job_q     <= job_d;
            rr_ptr_q  <= rr_ptr_d;
            rst_cnt_q <= RCW'(ENGINE_RST_CYCLES - 1);
            state_q   <= ENG_RST;
          end
        end
        ENG_RST: begin
          if (rst_cnt_q == '0) begin
            start_q <= 1'b1;
            state_q <= RUN;
`ifdef TB_JOB_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
          end else begin
            rst_cnt_q <= rst_cnt_q - 1'b1;
          end
        end
        RUN: begin
          if (tb_stop_traceback) begin
            resp_num_q   <= tb_num_compact;
            resp_id_q    <= job_q.id;
            resp_valid_q <= 1'b1;
            start_q      <= 1'b0;
            state_q      <= RESP;
`ifdef TB_JOB_TIMEOUT_EN
            resp_timeout_q <= 1'b0;
          end else if (tmo_cnt_q == TMW'(TIMEOUT_CYCLES - 1)) begin
            // Engine hung: report an empty result flagged as timed out.
            resp_num_q     <= '0;
            resp_id_q      <= job_q.id;
            resp_valid_q   <= 1'b1;
            resp_timeout_q <= 1'b1;
            start_q        <= 1'b0;
            state_q        <= RESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
`ifdef TB_JOB_TIMEOUT_EN
            resp_timeout_q <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Grant is only offered while idle and never during the reset cycle itself.
  assign req_ready          = (state_q == IDLE && !rst) ? grant : '0;
  assign tb_rst             = rst | (state_q == ENG_RST);
  assign tb_start_traceback = start_q;
  assign tb_start_diag      = job_q.diag;
  assign tb_start_score     = job_q.score;
  assign tb_state_out       = job_q.tb_state;
  assign resp_valid         = resp_valid_q;
  assign resp_id            = resp_id_q;
  assign resp_num_compact   = resp_num_q;
  assign busy               = (state_q != IDLE);
  assign dbg_state          = state_q;
`ifdef TB_JOB_TIMEOUT_EN
  assign resp_timeout       = resp_timeout_q;
`endif

endmodule

// File: tb/tb_tb_job_scheduler.sv
// Bench for tb_job_scheduler: directed scenarios plus randomized jobs against a
// lane-queue reference model. Define TB_JOB_TIMEOUT_EN to exercise the watchdog.
module tb_tb_job_scheduler;
  import tb_sched_pkg::*;

  localparam int N  = 4;
  localparam int W  = 5;
  localparam int RC = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_start_diag;
  logic [N*W-1:0] req_start_score;
  logic [N*2-1:0] req_tb_state;
  logic           tb_rst;
  logic           tb_start_traceback;
  logic [W-1:0]   tb_start_diag;
  logic [W-1:0]   tb_start_score;
  logic [1:0]     tb_state_out;
  logic           tb_stop_traceback;
  logic [W-1:0]   tb_num_compact;
  logic           resp_valid;
  logic           resp_ready;
  logic [1:0]     resp_id;
  logic [W-1:0]   resp_num_compact;
  logic           busy;
  state_t         dbg_state;
`ifdef TB_JOB_TIMEOUT_EN
  logic           resp_timeout;
`endif

  always #5 clk = ~clk;

  tb_job_scheduler #(
    .NUM_REQ               (N),
    .LOG_NUM_REQ           (2),
    .LOG_MAX_WAVEFRONT_LEN (W),
    .ENGINE_RST_CYCLES     (RC)
`ifdef TB_JOB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES        (16)
`endif
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_start_diag     (req_start_diag),
    .req_start_score    (req_start_score),
    .req_tb_state       (req_tb_state),
    .tb_rst             (tb_rst),
    .tb_start_traceback (tb_start_traceback),
    .tb_start_diag      (tb_start_diag),
    .tb_start_score     (tb_start_score),
    .tb_state_out       (tb_state_out),
    .tb_stop_traceback  (tb_stop_traceback),
    .tb_num_compact     (tb_num_compact),
    .resp_valid         (resp_valid),
    .resp_ready         (resp_ready),
    .resp_id            (resp_id),
    .resp_num_compact   (resp_num_compact),
    .busy               (busy),
`ifdef TB_JOB_TIMEOUT_EN
    .resp_timeout       (resp_timeout),
`endif
    .dbg_state          (dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ptr_m = 0;
  logic [W-1:0] l_diag[N];
  logic [W-1:0] l_score[N];
  logic [1:0]   l_st[N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fields(input bit rnd);
    for (int i = 0; i < N; i++) begin
      if (rnd) begin
        l_diag[i]  = W'($urandom);
        l_score[i] = W'($urandom);
        l_st[i]    = 2'($urandom);
      end
      req_start_diag[i*W +: W]  = l_diag[i];
      req_start_score[i*W +: W] = l_score[i];
      req_tb_state[i*2 +: 2]    = l_st[i];
    end
  endtask

  // Reference: first requesting lane at or after the pointer, wrapping around.
  function automatic int model_pick(input logic [N-1:0] mask, input int p);
    for (int k = 0; k < N; k++)
      if (mask[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    ptr_m = 0;
  endtask

  task automatic run_job(input logic [N-1:0] mask, input bit rnd, input int delay,
                         input logic [W-1:0] cnt, input int hold, input bit stop_in_rst);
    int lane;
    int n;
    drive_fields(rnd);
    req_valid = mask;
    #1;
    lane = model_pick(mask, ptr_m);
    check("grant_onehot", 32'(req_ready), 32'(1) << lane);
    check("busy_idle", 32'(busy), 32'd0);
    tick();
    ptr_m = (lane + 1) % N;
    check("busy_job", 32'(busy), 32'd1);
    check("no_grant_busy", 32'(req_ready), 32'd0);
    n = 0;
    while (tb_rst === 1'b1 && n < 20) begin
      check("start_low_in_rst", 32'(tb_start_traceback), 32'd0);
      if (stop_in_rst && n == 0) tb_stop_traceback = 1'b1;
      n++;
      tick();
      tb_stop_traceback = 1'b0;
    end
    check("eng_rst_len", 32'(n), 32'(RC));
    check("start_high", 32'(tb_start_traceback), 32'd1);
    check("resp_idle_run", 32'(resp_valid), 32'd0);
    check("job_diag", 32'(tb_start_diag), 32'(l_diag[lane]));
    check("job_score", 32'(tb_start_score), 32'(l_score[lane]));
    check("job_state", 32'(tb_state_out), 32'(l_st[lane]));
    for (int d = 0; d < delay; d++) begin
      tb_num_compact = W'($urandom);
      tick();
      check("start_held", 32'(tb_start_traceback), 32'd1);
      check("no_grant_run", 32'(req_ready), 32'd0);
    end
    tb_stop_traceback = 1'b1;
    tb_num_compact    = cnt;
    tick();
    tb_stop_traceback = 1'b0;
    tb_num_compact    = W'($urandom);
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_id", 32'(resp_id), 32'(lane));
    check("resp_num", 32'(resp_num_compact), 32'(cnt));
    check("start_drop", 32'(tb_start_traceback), 32'd0);
`ifdef TB_JOB_TIMEOUT_EN
    check("resp_timeout_clear", 32'(resp_timeout), 32'd0);
`endif
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_id", 32'(resp_id), 32'(lane));
      check("hold_num", 32'(resp_num_compact), 32'(cnt));
      check("no_grant_resp", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("resp_done", 32'(resp_valid), 32'd0);
    check("busy_done", 32'(busy), 32'd0);
    req_valid = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; req_valid = '1; resp_ready = 1'b0;
    tb_stop_traceback = 1'b0; tb_num_compact = '0;
    for (int i = 0; i < N; i++) begin l_diag[i] = '0; l_score[i] = '0; l_st[i] = '0; end
    drive_fields(1'b0);
    tick();
    tick();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_tb_rst", 32'(tb_rst), 32'd1);
    check("rst_start", 32'(tb_start_traceback), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_resp_num", 32'(resp_num_compact), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_diag", 32'(tb_start_diag), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0; req_valid = '0; ptr_m = 0;
    #1;
    check("idle_tb_rst", 32'(tb_rst), 32'd0);

    // Single directed job on lane 2.
    l_diag[2] = 5'd5; l_score[2] = 5'd9; l_st[2] = 2'd0;
    run_job(4'b0100, 1'b0, 19, 5'd7, 0, 1'b0);

    // Stop pulse while idle is ignored.
    tb_stop_traceback = 1'b1;
    tick();
    tb_stop_traceback = 1'b0;
    check("stop_idle_resp", 32'(resp_valid), 32'd0);
    check("stop_idle_busy", 32'(busy), 32'd0);

    // Consumer stalls for 10 cycles, then a stop pulse during engine reset.
    run_job(4'b0001, 1'b1, 3, 5'd13, 10, 1'b0);
    run_job(4'b1000, 1'b1, 2, 5'd21, 1, 1'b1);

    // All lanes continuously valid from a fresh reset: grants 0,1,2,3,0,1,2,3.
    do_reset();
    for (int j = 0; j < 8; j++) begin
      check("rr_order_model", 32'(model_pick(4'b1111, ptr_m)), 32'(j % N));
      run_job(4'b1111, 1'b1, int'($urandom_range(0, 4)), W'($urandom), 0, 1'b0);
    end

    // Reset during RUN.
    req_valid = 4'b1000;
    #1;
    tick();
    req_valid = '0;
    n = 0;
    while (tb_start_traceback !== 1'b1 && n < 20) begin n++; tick(); end
    check("midrst_reached_run", 32'(tb_start_traceback), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    check("midrst_resp", 32'(resp_valid), 32'd0);
    check("midrst_start", 32'(tb_start_traceback), 32'd0);
    check("midrst_tb_rst", 32'(tb_rst), 32'd1);
    rst = 1'b0; ptr_m = 0;
    req_valid = 4'b1111;
    #1;
    check("midrst_ptr_zero", 32'(req_ready), 32'b0001);
    run_job(4'b0010, 1'b1, 4, 5'd3, 2, 1'b0);

    // Randomized jobs against the model.
    for (int j = 0; j < 12; j++) begin
      logic [N-1:0] m;
      m = N'($urandom_range(1, (1 << N) - 1));
      run_job(m, 1'b1, int'($urandom_range(0, 6)), W'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

`ifdef TB_JOB_TIMEOUT_EN
    // Engine never stops: watchdog reports an empty timed-out result.
    begin
      int lane;
      drive_fields(1'b1);
      req_valid = 4'b0100;
      #1;
      lane = model_pick(4'b0100, ptr_m);
      check("tmo_grant", 32'(req_ready), 32'(1) << lane);
      tick();
      ptr_m = (lane + 1) % N;
      req_valid = '0;
      n = 0;
      while (tb_start_traceback !== 1'b1 && n < 20) begin n++; tick(); end
      n = 0;
      while (resp_valid !== 1'b1 && n < 100) begin n++; tick(); end
      check("tmo_run_cycles", 32'(n), 32'd16);
      check("tmo_flag", 32'(resp_timeout), 32'd1);
      check("tmo_num", 32'(resp_num_compact), 32'd0);
      check("tmo_id", 32'(resp_id), 32'(lane));
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("tmo_done", 32'(resp_valid), 32'd0);
      run_job(4'b0001, 1'b1, 5, 5'd11, 0, 1'b0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
